// File: rtl/inv_selftest.sv
// Self-test engine for a WIDTH-bit inverter: steps six fixed vectors, checks q against ~d at end of each hold window.
// Latency: done rises 6*HOLD edges after the start edge. No backpressure; start is ignored while a run is active.
module inv_selftest #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] d_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_count,
  output logic [2:0]       fail_index
);

  localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic [2:0]       err_q, err_d;
  logic [2:0]       fidx_q, fidx_d;
  logic             pass_q, pass_d;

  function automatic logic [WIDTH-1:0] pat(input logic [2:0] idx);
    logic [WIDTH-1:0] alt;
    for (int i = 0; i < WIDTH; i++) alt[i] = ((i % 2) == 1);
    case (idx)
      3'd0:    pat = '1;
      3'd1:    pat = '0;
      3'd2:    pat = {{HALF{1'b1}}, {HALF{1'b0}}};
      3'd3:    pat = {{HALF{1'b0}}, {HALF{1'b1}}};
      3'd4:    pat = alt;
      3'd5:    pat = '1;
      default: pat = '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    d_out_d = d_out_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = 3'd0;
          hold_d  = '0;
          d_out_d = pat(3'd0);
          err_d   = 3'd0;
          fidx_d  = 3'd7;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (hold_q == HW'(HOLD - 1)) begin
          hold_d = '0;
          // Only the last cycle of the window is checked; earlier cycles absorb settling.
          if (q_in != ~pat(vec_q)) begin
            err_d = err_q + 3'd1;
            if (fidx_q == 3'd7) fidx_d = vec_q;
          end
          if (vec_q == 3'd5) begin
            state_d = DONE;
            d_out_d = '0;
            pass_d  = (err_d == 3'd0);
          end else begin
            vec_d   = vec_q + 3'd1;
            d_out_d = pat(vec_q + 3'd1);
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      hold_q  <= '0;
      d_out_q <= '0;
      err_q   <= 3'd0;
      fidx_q  <= 3'd7;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      d_out_q <= d_out_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
    end
  end

  assign d_out      = d_out_q;
  assign busy       = (state_q == DRIVE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_index = fidx_q;

endmodule

// File: tb/tb_inv_selftest.sv
// Directed bench for inv_selftest: inverter models of varying correctness feed q_in.
module tb_inv_selftest;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] d_out;
  logic [3:0] q_in;
  logic       busy, done, pass;
  logic [2:0] err_count, fail_index;

  int n_cmp  = 0;
  int n_fail = 0;
  int mode   = 0;  // 0 inverter, 1 tied zero, 2 buffer, 3 bit0 flipped on 1010

  logic [3:0] pats [6] = '{4'b1111, 4'b0000, 4'b1100, 4'b0011, 4'b1010, 4'b1111};

  inv_selftest #(.WIDTH(4), .HOLD(4)) dut (
    .clk(clk), .reset(reset), .start(start), .d_out(d_out), .q_in(q_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       q_in = 4'b0000;
      2:       q_in = d_out;
      3:       q_in = ~d_out ^ ((d_out == 4'b1010) ? 4'b0001 : 4'b0000);
      default: q_in = ~d_out;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".d_out"}, 32'(d_out), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".done"}, 32'(done), 32'h0);
    chk({tag, ".pass"}, 32'(pass), 32'h0);
    chk({tag, ".err"}, 32'(err_count), 32'h0);
    chk({tag, ".fidx"}, 32'(fail_index), 32'h7);
  endtask

  // Pulses start, then follows the run edge by edge; restart_at > 0 pulses start again mid-run.
  task automatic do_run(input string tag, input int exp_err, input int exp_fi, input int restart_at);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, ".init_busy"}, 32'(busy), 32'h1);
    chk({tag, ".init_done"}, 32'(done), 32'h0);
    chk({tag, ".init_err"}, 32'(err_count), 32'h0);
    chk({tag, ".init_fidx"}, 32'(fail_index), 32'h7);
    chk({tag, ".init_d"}, 32'(d_out), 32'(pats[0]));
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      start = (j == restart_at);
      if (j < 24) begin
        chk($sformatf("%s.d_out@%0d", tag, j), 32'(d_out), 32'(pats[j / 4]));
        chk($sformatf("%s.busy@%0d", tag, j), 32'(busy), 32'h1);
        chk($sformatf("%s.done@%0d", tag, j), 32'(done), 32'h0);
      end else begin
        chk({tag, ".done"}, 32'(done), 32'h1);
        chk({tag, ".busy_end"}, 32'(busy), 32'h0);
        chk({tag, ".d_end"}, 32'(d_out), 32'h0);
        chk({tag, ".pass"}, 32'(pass), 32'(exp_err == 0));
        chk({tag, ".err"}, 32'(err_count), 32'(exp_err));
        chk({tag, ".fidx"}, 32'(fail_index), 32'(exp_fi));
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".done_hold"}, 32'(done), 32'h1);
    chk({tag, ".err_hold"}, 32'(err_count), 32'(exp_err));
    chk({tag, ".pass_hold"}, 32'(pass), 32'(exp_err == 0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    #1;
    chk_idle("reset");
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("idle_wait");

    mode = 0; do_run("good", 0, 7, 0);
    mode = 1; do_run("zero", 4, 1, 0);
    mode = 2; do_run("buffer", 6, 0, 0);
    mode = 3; do_run("flip", 1, 4, 0);
    mode = 0; do_run("restart_ign", 0, 7, 10);

    // Abort a run with reset part-way through.
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort.busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk_idle("abort");
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    chk_idle("abort_idle");

    mode = 0; do_run("after_reset", 0, 7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
